// File: rtl/trigger_framer.sv
// trigger_framer: threshold trigger that frames each above-threshold burst of
// ADC samples as an AXI-stream packet (header, data beats, time-stamped footer).
//
// Handshake semantics: a beat transfers on a rising clock edge where both
// TVALID and TREADY are high. Registered beats (header, footer) are held
// stable while TVALID=1 and TREADY=0. Data beats are a combinational
// pass-through of the slave stream, so they hold exactly as long as the
// upstream source holds its sample.
module trigger_framer #(
  parameter int         ADC_DATA_WIDTH   = 16,
  parameter int         TIME_STAMP_WIDTH = 16,
  parameter logic [7:0] CH_ID            = 8'h00,
  parameter int         MAX_SAMPLE_NUM   = 1024
) (
  input  logic                               AXIS_ACLK,
  input  logic                               AXIS_ARESETN,
  input  logic signed [ADC_DATA_WIDTH-1:0]   THRESHOLD_VAL,
  input  logic        [TIME_STAMP_WIDTH-1:0] CURRENT_TIME,
  output logic        [1:0]                  EXEC_STATE,
  input  logic signed [ADC_DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                               S_AXIS_TVALID,
  output logic                               S_AXIS_TREADY,
  output logic        [31:0]                 M_AXIS_TDATA,
  output logic                               M_AXIS_TVALID,
  input  logic                               M_AXIS_TREADY,
  output logic                               M_AXIS_TLAST
);

  // State codes double as the EXEC_STATE value seen by time_counter.
  localparam logic [1:0] ST_INIT     = 2'b00;
  localparam logic [1:0] ST_HEADER   = 2'b01;
  localparam logic [1:0] ST_TRG      = 2'b11;
  localparam logic [1:0] ST_FINALIZE = 2'b10;

  localparam int         PAD_W   = 32 - ADC_DATA_WIDTH;
  localparam logic [15:0] MAX_CNT = 16'(MAX_SAMPLE_NUM);

  logic        [1:0]                  state_q,  state_d;
  logic signed [ADC_DATA_WIDTH-1:0]   thr_q,    thr_d;
  logic signed [ADC_DATA_WIDTH-1:0]   trig_q,   trig_d;
  logic        [15:0]                 count_q,  count_d;
  logic        [31:0]                 footer_q, footer_d;
  logic                               above;

  assign EXEC_STATE = state_q;

  // Next-state, datapath and output decode for the framing FSM.
  always_comb begin
    above         = (S_AXIS_TDATA > thr_q);
    state_d       = state_q;
    thr_d         = (state_q == ST_INIT) ? THRESHOLD_VAL : thr_q;
    trig_d        = trig_q;
    count_d       = count_q;
    footer_d      = footer_q;
    S_AXIS_TREADY = 1'b0;
    M_AXIS_TVALID = 1'b0;
    M_AXIS_TLAST  = 1'b0;
    M_AXIS_TDATA  = 32'h0;
    case (state_q)
      ST_INIT: begin
        // Everything is consumed here; only an above-threshold sample is kept.
        S_AXIS_TREADY = 1'b1;
        if (S_AXIS_TVALID && above) begin
          trig_d  = S_AXIS_TDATA;
          count_d = 16'd1;
          state_d = ST_HEADER;
        end
      end
      ST_HEADER: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TDATA  = {8'hAA, CH_ID, trig_q};
        if (M_AXIS_TREADY) begin
          state_d = ST_TRG;
        end
      end
      ST_TRG: begin
        // Below-threshold samples are swallowed even under backpressure so
        // that the burst can terminate without waiting on downstream.
        M_AXIS_TDATA  = {{PAD_W{S_AXIS_TDATA[ADC_DATA_WIDTH-1]}}, S_AXIS_TDATA};
        M_AXIS_TVALID = S_AXIS_TVALID & above;
        S_AXIS_TREADY = M_AXIS_TREADY | ~above;
        if (S_AXIS_TVALID && S_AXIS_TREADY) begin
          if (above) begin
            if (count_q < MAX_CNT) begin
              count_d = count_q + 16'd1;
            end
            if (count_q == MAX_CNT - 16'd1) begin
              state_d = ST_FINALIZE;
            end
          end else begin
            state_d = ST_FINALIZE;
          end
        end
        if (state_d == ST_FINALIZE) begin
          footer_d = {CURRENT_TIME, count_d};
        end
      end
      ST_FINALIZE: begin
        M_AXIS_TVALID = 1'b1;
        M_AXIS_TLAST  = 1'b1;
        M_AXIS_TDATA  = footer_q;
        if (M_AXIS_TREADY) begin
          state_d = ST_INIT;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESETN) begin
      state_q  <= ST_INIT;
      thr_q    <= '0;
      trig_q   <= '0;
      count_q  <= 16'd0;
      footer_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      thr_q    <= thr_d;
      trig_q   <= trig_d;
      count_q  <= count_d;
      footer_q <= footer_d;
    end
  end

endmodule
